// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared definitions for APB completers: the phase-tracking
//               state encoding, register-bank word indices and a saturating
//               increment helper for the transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    // Phase seen on the previous clock cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam logic [3:0] REG_ID      = 4'd12;
    localparam logic [3:0] REG_WCNT    = 4'd13;
    localparam logic [3:0] REG_RCNT    = 4'd14;
    localparam logic [3:0] REG_STAT    = 4'd15;
    localparam int         NUM_SCRATCH = 12;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_regbank_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_regbank_slave_if
// Description : APB bus bundle between the bridge (master) and a completer
//               (slave).
//   Pselx[2:0]   - slot selects
//   Penable      - access-phase strobe
//   Pwrite       - 1 = write, 0 = read
//   Paddr[31:0]  - byte address
//   Pwdata[31:0] - write data
//   Prdata[31:0] - read data (driven by the completer)
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_regbank_slave_if;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata);
    modport slave  (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata);
endinterface
`default_nettype wire

// File: rtl/apb_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_fsm
// Description : APB phase tracker. Classifies the current bus cycle from the
//               previous phase plus sel/Penable, latches the word index and
//               direction in the setup cycle and checks them in the access
//               cycle. Strobes are valid during the cycle whose ending edge
//               performs the action.
//   Hclk, Hresetn - clock, synchronous active-low reset
//   i_sel         - this slot selected
//   i_penable     - access-phase strobe
//   i_pwrite      - direction of the current cycle
//   i_widx[3:0]   - word index of the current cycle
//   wr_commit     - commit a write at this edge
//   rd_load       - load read data at this edge (setup cycle of a read)
//   rd_done       - a read completes at this edge
//   proto_err     - protocol violation at this edge
//   idx[3:0]      - word index latched in the setup cycle
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_fsm
    import apb_pkg::*;
(
    input  wire logic       Hclk,
    input  wire logic       Hresetn,
    input  wire logic       i_sel,
    input  wire logic       i_penable,
    input  wire logic       i_pwrite,
    input  wire logic [3:0] i_widx,
    output logic            wr_commit,
    output logic            rd_load,
    output logic            rd_done,
    output logic            proto_err,
    output logic [3:0]      idx
);

    apb_state_t r_state;
    logic       r_write;
    logic       w_setup;
    logic       w_access;
    logic       w_match;

    always_comb begin
        w_setup   = 1'b0;
        w_access  = 1'b0;
        proto_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_sel && i_penable)  proto_err = 1'b1;
                else if (i_sel)          w_setup   = 1'b1;
            end
            SETUP: begin
                if (!i_sel)              proto_err = 1'b1;
                else if (i_penable)      w_access  = 1'b1;
                else begin
                    // Repeated setup: flag it and treat as a fresh setup.
                    proto_err = 1'b1;
                    w_setup   = 1'b1;
                end
            end
            ACCESS: begin
                if (i_sel && i_penable)  proto_err = 1'b1;
                else if (i_sel)          w_setup   = 1'b1;
            end
            default: ;
        endcase
        w_match = (i_widx == idx) && (i_pwrite == r_write);
        if (w_access && !w_match) proto_err = 1'b1;
    end

    assign wr_commit = w_access && w_match &&  r_write;
    assign rd_done   = w_access && w_match && !r_write;
    assign rd_load   = w_setup && !i_pwrite;

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            idx     <= 4'd0;
        end else begin
            if (w_setup) begin
                idx     <= i_widx;
                r_write <= i_pwrite;
            end
            if (w_setup)       r_state <= SETUP;
            else if (w_access) r_state <= ACCESS;
            else               r_state <= IDLE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_regbank_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_regbank_slave
// Description : APB completer with a 16-word register bank: 12 scratch words,
//               ID word, write/read transfer counters and a sticky W1C
//               protocol-error status. Read data is registered in the setup
//               cycle so it is stable for the whole zero-wait access cycle.
//   Hclk     - clock
//   Hresetn  - synchronous active-low reset
//   bus      - APB slave modport (Pselx/Penable/Pwrite/Paddr/Pwdata/Prdata)
//   perr_irq - level copy of the sticky protocol-error bit
// Revision    : 1.0 - initial release
// ============================================================================
module apb_regbank_slave
    import apb_pkg::*;
#(
    parameter int          SLOT     = 0,
    parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
)(
    input  wire logic           Hclk,
    input  wire logic           Hresetn,
    apb_regbank_slave_if.slave  bus,
    output logic                perr_irq
);

    logic        w_sel;
    logic [3:0]  w_widx;
    logic        w_wr_commit;
    logic        w_rd_load;
    logic        w_rd_done;
    logic        w_proto_err;
    logic [3:0]  w_idx;
    logic [31:0] w_rdata;
    logic        w_unused;

    logic [31:0] r_scratch [NUM_SCRATCH];
    logic [31:0] r_wcnt;
    logic [31:0] r_rcnt;
    logic        r_err;

    assign w_sel    = bus.Pselx[SLOT];
    assign w_widx   = bus.Paddr[5:2];
    assign w_unused = ^{bus.Pselx, bus.Paddr[31:6], bus.Paddr[1:0]};

    apb_slave_fsm u_fsm (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .i_sel     (w_sel),
        .i_penable (bus.Penable),
        .i_pwrite  (bus.Pwrite),
        .i_widx    (w_widx),
        .wr_commit (w_wr_commit),
        .rd_load   (w_rd_load),
        .rd_done   (w_rd_done),
        .proto_err (w_proto_err),
        .idx       (w_idx)
    );

    // Read mux on the setup-cycle address; counters show pre-transfer values.
    always_comb begin
        w_rdata = 32'd0;
        case (w_widx)
            REG_ID:   w_rdata = ID_VALUE;
            REG_WCNT: w_rdata = r_wcnt;
            REG_RCNT: w_rdata = r_rcnt;
            REG_STAT: w_rdata = {31'd0, r_err};
            default:  w_rdata = r_scratch[w_widx];
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= 32'd0;
            r_wcnt     <= 32'd0;
            r_rcnt     <= 32'd0;
            r_err      <= 1'b0;
            bus.Prdata <= 32'd0;
        end else begin
            if (w_rd_load) bus.Prdata <= w_rdata;
            // Writes to read-only words are dropped but still counted.
            if (w_wr_commit && (32'(w_idx) < NUM_SCRATCH))
                r_scratch[w_idx] <= bus.Pwdata;
            if (w_wr_commit) r_wcnt <= sat_inc(r_wcnt);
            if (w_rd_done)   r_rcnt <= sat_inc(r_rcnt);
            // A new violation outranks a simultaneous W1C.
            if (w_proto_err)
                r_err <= 1'b1;
            else if (w_wr_commit && (w_idx == REG_STAT) && bus.Pwdata[0])
                r_err <= 1'b0;
        end
    end

    assign perr_irq = r_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_regbank_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_regbank_slave
// Description : Directed self-checking bench for apb_regbank_slave. A small
//               register model predicts read data, which is queued when a
//               read is issued and compared in its access cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_regbank_slave;

    localparam int          SLOT = 1;
    localparam logic [31:0] ID   = 32'hA5B0_0001;
    localparam logic [2:0]  OURS = 3'b001 << SLOT;

    logic Hclk    = 1'b0;
    logic Hresetn = 1'b0;
    logic perr_irq;

    apb_regbank_slave_if bus ();

    apb_regbank_slave #(.SLOT(SLOT), .ID_VALUE(ID)) dut (
        .Hclk     (Hclk),
        .Hresetn  (Hresetn),
        .bus      (bus),
        .perr_irq (perr_irq)
    );

    always #5 Hclk = ~Hclk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q [$];
    logic [31:0] m_scr [12];
    logic [31:0] m_wcnt;
    logic [31:0] m_rcnt;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 12; i++) m_scr[i] = 32'd0;
        m_wcnt = 32'd0;
        m_rcnt = 32'd0;
        m_err  = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] i);
        case (i)
            4'd12:   return ID;
            4'd13:   return m_wcnt;
            4'd14:   return m_rcnt;
            4'd15:   return {31'd0, m_err};
            default: return m_scr[i];
        endcase
    endfunction

    // Our select bit plus random noise on the other slots.
    function automatic logic [2:0] sel_bits();
        return 3'($urandom_range(0, 7)) | OURS;
    endfunction

    // One legal transfer; leaves the bus in access so a following call
    // forms a back-to-back transfer.
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
        logic [3:0]  i;
        logic [31:0] exp;
        i = addr[5:2];
        if (!wr) sb_q.push_back(m_read(i));
        bus.Pselx   = sel_bits();
        bus.Penable = 1'b0;
        bus.Pwrite  = wr;
        bus.Paddr   = addr;
        bus.Pwdata  = wdata;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        bus.Pselx   = sel_bits();
        @(negedge Hclk);
        if (!wr) begin
            exp = sb_q.pop_front();
            check(tag, bus.Prdata, exp);
        end
        @(posedge Hclk); #1;
        if (wr) begin
            if (i < 4'd12) m_scr[i] = wdata;
            if (i == 4'd15 && wdata[0]) m_err = 1'b0;
            if (m_wcnt != 32'hFFFF_FFFF) m_wcnt++;
        end else begin
            if (m_rcnt != 32'hFFFF_FFFF) m_rcnt++;
        end
    endtask

    task automatic idle(input int n);
        bus.Pselx   = 3'($urandom_range(0, 7)) & ~OURS;
        bus.Penable = 1'b0;
        repeat (n) begin
            @(posedge Hclk); #1;
        end
    endtask

    task automatic idle_perr(input logic exp, input string tag);
        bus.Pselx   = 3'($urandom_range(0, 7)) & ~OURS;
        bus.Penable = 1'b0;
        @(negedge Hclk);
        check(tag, {31'd0, perr_irq}, {31'd0, exp});
        @(posedge Hclk); #1;
    endtask

    initial begin
        bus.Pselx   = 3'd0;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b0;
        bus.Paddr   = 32'd0;
        bus.Pwdata  = 32'd0;
        m_reset();
        repeat (3) @(posedge Hclk);
        @(negedge Hclk);
        check("rst_prdata", bus.Prdata, 32'd0);
        check("rst_perr", {31'd0, perr_irq}, 32'd0);
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
        idle(1);

        // Write then back-to-back read, then the counters.
        xfer(1'b1, 32'h08, 32'hDEAD_BEEF, "wr_08");
        xfer(1'b0, 32'h08, 32'd0, "rd_08");
        xfer(1'b0, 32'h34, 32'd0, "rd_wcnt_1");
        xfer(1'b0, 32'h38, 32'd0, "rd_rcnt_1");

        // ID is read-only; the write is still counted.
        xfer(1'b0, 32'h30, 32'd0, "rd_id");
        xfer(1'b1, 32'h30, 32'h1234, "wr_id");
        xfer(1'b0, 32'h30, 32'd0, "rd_id_again");
        xfer(1'b0, 32'h34, 32'd0, "rd_wcnt_2");
        idle(1);

        // Penable without setup.
        bus.Pselx   = sel_bits();
        bus.Penable = 1'b1;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h08;
        bus.Pwdata  = 32'h0BAD_0BAD;
        @(posedge Hclk); #1;
        m_err = 1'b1;
        idle_perr(1'b1, "perr_no_setup");
        xfer(1'b0, 32'h08, 32'd0, "rd_08_kept");
        xfer(1'b0, 32'h3C, 32'd0, "rd_stat_set");
        xfer(1'b1, 32'h3C, 32'd1, "w1c");
        idle_perr(1'b0, "perr_cleared");

        // Address moves between setup and access of a write.
        bus.Pselx   = sel_bits();
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h04;
        bus.Pwdata  = 32'hCAFE_F00D;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        bus.Paddr   = 32'h0C;
        @(posedge Hclk); #1;
        m_err = 1'b1;
        idle_perr(1'b1, "perr_mismatch");
        xfer(1'b0, 32'h04, 32'd0, "rd_04_kept");
        xfer(1'b0, 32'h0C, 32'd0, "rd_0c_kept");
        xfer(1'b0, 32'h34, 32'd0, "rd_wcnt_mm");
        xfer(1'b1, 32'h3C, 32'd1, "w1c_2");
        idle_perr(1'b0, "perr_cleared_2");

        // Transfer addressed to other slots only.
        bus.Pselx   = ~OURS;
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h00;
        bus.Pwdata  = 32'hFFFF_0000;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        @(posedge Hclk); #1;
        idle_perr(1'b0, "perr_other_slot");
        xfer(1'b0, 32'h00, 32'd0, "rd_00_other_slot");

        // All scratch words, with ignored high and low address bits.
        for (int i = 0; i < 12; i++)
            xfer(1'b1, 32'h0000_1001 + 32'(i) * 4, 32'h1111_0000 + 32'(i) * 32'h0101, "wr_scr");
        for (int i = 0; i < 12; i++)
            xfer(1'b0, 32'hFF00_0002 + 32'(i) * 4, 32'd0, "rd_scr");
        xfer(1'b0, 32'h3C, 32'd0, "rd_stat_clear");

        // Reset asserted in the access cycle of a write to word 0.
        xfer(1'b1, 32'h00, 32'h5555_5555, "wr_00");
        bus.Pselx   = sel_bits();
        bus.Penable = 1'b0;
        bus.Pwrite  = 1'b1;
        bus.Paddr   = 32'h00;
        bus.Pwdata  = 32'h7777_7777;
        @(posedge Hclk); #1;
        bus.Penable = 1'b1;
        Hresetn     = 1'b0;
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
        m_reset();
        bus.Pselx   = 3'($urandom_range(0, 7)) & ~OURS;
        bus.Penable = 1'b0;
        @(negedge Hclk);
        check("mid_rst_prdata", bus.Prdata, 32'd0);
        check("mid_rst_perr", {31'd0, perr_irq}, 32'd0);
        @(posedge Hclk); #1;

        // 100 back-to-back reads of the read counter.
        for (int n = 0; n < 100; n++)
            xfer(1'b0, 32'h38, 32'd0, "rd_rcnt_b2b");
        idle_perr(1'b0, "perr_b2b");
        xfer(1'b0, 32'h00, 32'd0, "rd_00_after_rst");
        xfer(1'b0, 32'h34, 32'd0, "rd_wcnt_after_rst");
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_regbank_slave.md
# apb_regbank_slave

APB completer (slave) that sits on the peripheral side of the AHB-to-APB bridge and answers one slot of its 3-bit select bus. Holds a 16-word register bank: 12 scratch registers, an ID word, read/write transfer counters and a sticky protocol-error status. It tracks the APB phase sequence with a small state machine. It returns registered read data that is stable for the whole access phase, because the bridge has no wait-state (`Pready`) path.

## Interface
Parameters:
- `SLOT` — default 0 — index of the `Pselx` bit this instance answers (0..2).
- `ID_VALUE` — default 32'hA5B0_0001 — constant returned by the ID register.

Ports:
- `Hclk` — in — 1 — single clock, shared with the bridge.
- `Hresetn` — in — 1 — reset, synchronous, active-low.
- `Pselx` — in — 3 — APB slot selects; only bit `SLOT` is used.
- `Penable` — in — 1 — APB access-phase strobe.
- `Pwrite` — in — 1 — 1 = write, 0 = read.
- `Paddr` — in — 32 — byte address; only [5:2] are decoded.
- `Pwdata` — in — 32 — write data, sampled in the access phase.
- `Prdata` — out — 32 — read data, valid during the access phase.
- `perr_irq` — out — 1 — level copy of the sticky protocol-error bit.

## Operation
- `sel` = `Pselx[SLOT]`. Word index = `Paddr[5:2]`. `Paddr[1:0]` and `Paddr[31:6]` are ignored.
- Register map:
  - Words 0–11: read/write scratch registers.
  - Word 12: `ID_VALUE`, read-only.
  - Word 13: completed write count, read-only.
  - Word 14: completed read count, read-only.
  - Word 15: status; bit0 = sticky protocol error, write-1-to-clear; other bits read 0.
- Writes to read-only words are accepted on the bus and discarded; they are still counted.
- State machine, states IDLE / SETUP / ACCESS:
  - IDLE:
    - `sel & !Penable` → SETUP.
    - `sel & Penable` → error, stay in IDLE.
    - Otherwise stay in IDLE.
  - SETUP: latch word index and `Pwrite`; for reads, also load `Prdata`. Then:
    - `sel & Penable` → ACCESS.
    - `sel & !Penable` → error, SETUP again (re-latch).
    - `!sel` → error, IDLE.
  - ACCESS: compare `Paddr[5:2]` and `Pwrite` against the latched values.
    - Mismatch → error, transfer suppressed.
    - Match → commit the write (`Pwdata`) or count the read at the clock edge ending ACCESS.
    - Next state: `sel & !Penable` → SETUP (back-to-back); `!sel` → IDLE; `sel & Penable` → error, IDLE.
- Counters are 32 bits wide, count only completed (non-suppressed) transfers, and saturate at 32'hFFFF_FFFF.
- Error set and W1C clear in the same cycle: set wins.

## Timing
- Reset values:
  - State = IDLE.
  - All scratch registers = 0; both counters = 0; error bit = 0.
  - `Prdata` = 0; `perr_irq` = 0.
- Read latency:
  - `Prdata` is registered on the edge that ends the setup cycle and holds until the next setup.
  - It is valid for the entire access cycle, so zero wait states.
  - Data reflects register contents at setup; a read of word 13/14 shows the count before the current transfer.
- Write latency: the register updates on the edge ending the access cycle and is readable by the next transfer's setup.
- `perr_irq` rises on the cycle after the violating edge.
- Reset asserted mid-transfer: the next edge returns everything to reset values, and no partial write occurs.

## Structure
- Shared package `apb_pkg`:
  - State enum `apb_state_t` (IDLE/SETUP/ACCESS).
  - Word-index constants `REG_ID=12`, `REG_WCNT=13`, `REG_RCNT=14`, `REG_STAT=15`, `NUM_SCRATCH=12`.
  - Reused later by other APB completers.
- One natural sub-module, `apb_slave_fsm`: phase tracking, latching, mismatch check. It outputs `wr_commit`, `rd_load`, `rd_done`, `proto_err`, `idx`.
- The top holds the register bank, counters and read mux.

## Test plan
- Write 32'hDEAD_BEEF to 0x08, then read 0x08 back to back → `Prdata` = 32'hDEAD_BEEF in the access cycle; word 13 = 1, word 14 = 1 afterwards.
- Read 0x30 → `ID_VALUE`. Write 0x1234 to 0x30 → no change; write count increments.
- `Penable` high with no preceding setup → `perr_irq` = 1 next cycle, no register change. Write 1 to 0x3C → `perr_irq` = 0.
- `Paddr` changes 0x04 → 0x0C between setup and access on a write → neither word written; error set; write count unchanged.
- 100 consecutive back-to-back reads of word 14 → the final access cycle returns 99 and `perr_irq` stays 0.
- `Hresetn` low during the access phase of a write to 0x00 → word 0 = 0, counters = 0, `Prdata` = 0; select bits of other slots ignored throughout.
